// File: rtl/keccak_masked_pkg.sv
// -----------------------------------------------------------------------------
// keccak_masked_pkg
// Shared definitions for the masked Keccak datapath:
//   - lane enumeration (A..E) and lane-offset arithmetic within a 5-bit row
//   - share bookkeeping for order-d masking: pair count, pair index,
//     share-sum index (i+j) mod (d+1), and fresh-randomness width per row
// No ports (package).
// -----------------------------------------------------------------------------
package keccak_masked_pkg;

    typedef enum logic [2:0] {
        LANE_A = 3'd0,
        LANE_B = 3'd1,
        LANE_C = 3'd2,
        LANE_D = 3'd3,
        LANE_E = 3'd4
    } lane_e;

    localparam int NUM_LANES = 5;

    // Number of unordered share pairs (i<j) at order d.
    function automatic int pair_count(input int d);
        return (d * (d + 1)) / 2;
    endfunction

    // Fresh random bits needed per 5-bit row.
    function automatic int rand_bits(input int d);
        return NUM_LANES * pair_count(d);
    endfunction

    // Dense index of the unordered pair (i,j); caller guarantees i < j.
    function automatic int pair_index(input int i, input int j);
        return i + (j * (j - 1)) / 2;
    endfunction

    // Share selected for the linear term of expansion pair (i,j).
    function automatic int share_sum(input int i, input int j, input int d);
        return (i + j) % (d + 1);
    endfunction

    // Lane reached by stepping 'off' lanes forward, wrapping mod 5.
    function automatic int lane_offset(input lane_e lane, input int off);
        return (int'(lane) + off) % NUM_LANES;
    endfunction

endpackage

// File: rtl/keccak_and_xor.sv
// -----------------------------------------------------------------------------
// keccak_and_xor
// Single-bit masked AND-XOR cell used for the chi share expansion:
//   q = ((a ^ INV_A) & b) ^ lin ^ mask
// INV_A is set only on share 0 of the inverted operand, which is how a
// masked NOT is applied (inverting one share inverts the shared value).
// Ports:
//   a    - share of the inverted chi operand (x[k+1])
//   b    - share of the plain chi operand (x[k+2])
//   lin  - linear share of x[k] (or 0 where the pair carries no linear term)
//   mask - fresh mask bit for this share pair (0 on the diagonal)
//   q    - expanded output share
// -----------------------------------------------------------------------------
module keccak_and_xor #(
    parameter logic INV_A = 1'b0
) (
    input  logic a,
    input  logic b,
    input  logic lin,
    input  logic mask,
    output logic q
);

    assign q = ((a ^ INV_A) & b) ^ lin ^ mask;

endmodule

// File: rtl/keccak_chi_compress.sv
// -----------------------------------------------------------------------------
// keccak_chi_compress
// Compresses one lane's (d+1)^2 expanded shares back to d+1 shares:
//   shares[i] = XOR over j of exp_shares[i*(d+1)+j]
// Purely combinational; its input must come straight from a register so that
// the expansion glitches never reach this XOR tree.
// Ports:
//   exp_shares - registered expanded shares of one lane, index i*(D+1)+j
//   shares     - compressed output shares of the lane
// -----------------------------------------------------------------------------
module keccak_chi_compress #(
    parameter int D = 3
) (
    input  logic [(D+1)*(D+1)-1:0] exp_shares,
    output logic [D:0]             shares
);

    always_comb begin
        // NOTE: assigning a default before the loops means every bit is
        // written on every pass, so no latch can be inferred; blocking '=' is
        // correct here because the accumulation reads its own partial result.
        shares = '0;
        for (int i = 0; i <= D; i++) begin
            for (int j = 0; j <= D; j++) begin
                shares[i] = shares[i] ^ exp_shares[i*(D+1)+j];
            end
        end
    end

endmodule

// File: rtl/keccak_chi_pipe.sv
// -----------------------------------------------------------------------------
// keccak_chi_pipe
// Two-stage pipelined, masked Keccak chi layer at security order D over ROWS
// independent 5-bit rows.
//   Stage 1: low-latency share expansion, (D+1)^2 shares per lane, refreshed
//            with fresh masks and registered in s1_q.
//   Stage 2: XOR compression back to D+1 shares per lane, registered in s2_q,
//            which drives out_data directly.
// Latency 2 cycles, throughput 1 transaction/cycle, valid/ready on both sides.
// Ports:
//   clk, rst   - clock; asynchronous active-high reset
//   in_valid   - input transaction valid
//   in_ready   - block accepts input this cycle (depends on out_ready only)
//   in_data    - shared input, bit (row*5+lane)*(D+1)+share, lane 0..4 = a..e
//   in_rand    - fresh masks, row r uses [r*RW +: RW]; sampled on acceptance
//   flush      - synchronous clear of both stages; concurrent input dropped
//   out_valid  - output transaction valid
//   out_ready  - downstream accepts output
//   out_data   - shared chi result, same packing as in_data
// -----------------------------------------------------------------------------
module keccak_chi_pipe
    import keccak_masked_pkg::*;
#(
    parameter int D    = 3,
    parameter int ROWS = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [ROWS*NUM_LANES*(D+1)-1:0]   in_data,
    input  logic [ROWS*rand_bits(D)-1:0]      in_rand,
    input  logic                              flush,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ROWS*NUM_LANES*(D+1)-1:0]   out_data
);

    localparam int NS     = D + 1;
    localparam int NP     = pair_count(D);
    localparam int RW     = rand_bits(D);
    localparam int LANE_W = ROWS * NUM_LANES;
    localparam int EXP_W  = LANE_W * NS * NS;
    localparam int DATA_W = LANE_W * NS;

    logic [EXP_W-1:0]  exp_d;
    logic [EXP_W-1:0]  s1_q;
    logic              s1_v;
    logic [DATA_W-1:0] cmp_d;
    logic [DATA_W-1:0] s2_q;
    logic              s2_v;
    logic              s2_load;
    logic              accept;

    // ------------------------------------------------------------------
    // Share expansion: for lane k and share pair (i,j)
    //   x'(i,j) = ~x[k+1]_i & x[k+2]_j ^ lin(i,j) ^ fm[k][i][j]
    // The linear share of x[k] is folded in exactly once per share, in column
    // j == 0 where share_sum(i,0) == i. Putting it into every pair would XOR
    // each share D+1 times and cancel it whenever D+1 is even.
    // Masks are symmetric with a zero diagonal, so they vanish in the total.
    // ------------------------------------------------------------------
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
            localparam int LA = r*NUM_LANES + k;
            localparam int LB = r*NUM_LANES + lane_offset(lane_e'(k), 1);
            localparam int LC = r*NUM_LANES + lane_offset(lane_e'(k), 2);
            localparam int MB = r*RW + k*NP;

            for (genvar i = 0; i < NS; i++) begin : g_i
                for (genvar j = 0; j < NS; j++) begin : g_j
                    logic lin_bit;
                    logic mask_bit;

                    if (j == 0) begin : g_lin
                        assign lin_bit = in_data[LA*NS + share_sum(i, j, D)];
                    end else begin : g_nolin
                        assign lin_bit = 1'b0;
                    end

                    if (i == j) begin : g_diag
                        assign mask_bit = 1'b0;
                    end else if (i < j) begin : g_upper
                        assign mask_bit = in_rand[MB + pair_index(i, j)];
                    end else begin : g_lower
                        assign mask_bit = in_rand[MB + pair_index(j, i)];
                    end

                    keccak_and_xor #(
                        .INV_A ((i == 0) ? 1'b1 : 1'b0)
                    ) u_and_xor (
                        .a    (in_data[LB*NS + i]),
                        .b    (in_data[LC*NS + j]),
                        .lin  (lin_bit),
                        .mask (mask_bit),
                        .q    (exp_d[(LA*NS + i)*NS + j])
                    );
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Compression, fed only from the stage-1 register.
    // ------------------------------------------------------------------
    for (genvar l = 0; l < LANE_W; l++) begin : g_cmp
        keccak_chi_compress #(
            .D (D)
        ) u_compress (
            .exp_shares (s1_q[l*NS*NS +: NS*NS]),
            .shares     (cmp_d[l*NS +: NS])
        );
    end

    // ------------------------------------------------------------------
    // Flow control. in_ready depends on state and out_ready only.
    // When in_ready is high, stage 1 is either empty or moving into stage 2,
    // so its next valid is simply whether an input is accepted.
    // ------------------------------------------------------------------
    assign s2_load  = !s2_v || out_ready;
    assign in_ready = !s1_v || s2_load;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the wide data registers are cleared too, so out_data reads
            // zero during reset and no stale shares survive a mid-run reset;
            // non-blocking '<=' keeps every stage reading pre-edge values.
            s1_v <= 1'b0;
            s1_q <= '0;
            s2_v <= 1'b0;
            s2_q <= '0;
        end else if (flush) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_q <= cmp_d;
                end
            end
            if (in_ready) begin
                s1_v <= accept;
                if (accept) begin
                    s1_q <= exp_d;
                end
            end
        end
    end

    assign out_valid = s2_v;
    assign out_data  = s2_q;

endmodule

// File: tb/tb_keccak_chi_pipe.sv
// -----------------------------------------------------------------------------
// tb_keccak_chi_pipe
// Directed bench for keccak_chi_pipe. Main instance uses D=3, ROWS=1; a second
// instance uses D=1, ROWS=4 for the exhaustive per-row sweep. Expected values
// are hand-computed chi results; a scoreboard queue tracks in-flight order.
// -----------------------------------------------------------------------------
module tb_keccak_chi_pipe;

    localparam int NS0 = 4;
    localparam int W0  = 20;
    localparam int RW0 = 30;
    localparam int R1  = 4;
    localparam int NS1 = 2;
    localparam int W1  = 40;
    localparam int RW1 = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // main instance
    logic           in_valid, in_ready, flush, out_valid, out_ready;
    logic [W0-1:0]  in_data, out_data;
    logic [RW0-1:0] in_rand;

    // small instance
    logic           s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready;
    logic [W1-1:0]  s_in_data, s_out_data;
    logic [RW1-1:0] s_in_rand;

    keccak_chi_pipe #(.D(3), .ROWS(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_rand   (in_rand),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    keccak_chi_pipe #(.D(1), .ROWS(R1)) dut_small (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .in_rand   (s_in_rand),
        .flush     (s_flush),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data)
    );

    int tests = 0;
    int fails = 0;
    int n_out = 0;
    logic [4:0] exp_q[$];

    // hand-computed chi vectors
    logic [4:0] pat_in  [4] = '{5'b00001, 5'b00100, 5'b11111, 5'b00000};
    logic [4:0] pat_out [4] = '{5'b01001, 5'b00101, 5'b11111, 5'b00000};
    logic [4:0] st_in   [3] = '{5'b00010, 5'b00100, 5'b00001};
    logic [4:0] st_out  [3] = '{5'b10010, 5'b00101, 5'b01001};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] share_row(input logic [4:0] x, input int ns);
        logic [63:0] v;
        logic acc;
        v = '0;
        for (int l = 0; l < 5; l++) begin
            acc = x[l];
            for (int s = 1; s < ns; s++) begin
                v[l*ns+s] = 1'($urandom_range(0, 1));
                acc = acc ^ v[l*ns+s];
            end
            v[l*ns] = acc;
        end
        return v;
    endfunction

    function automatic logic [4:0] recomb(input logic [63:0] v, input int ns);
        logic [4:0] y;
        y = '0;
        for (int l = 0; l < 5; l++)
            for (int s = 0; s < ns; s++)
                y[l] = y[l] ^ v[l*ns+s];
        return y;
    endfunction

    function automatic logic [4:0] chi5(input logic [4:0] x);
        logic [4:0] y;
        for (int k = 0; k < 5; k++)
            y[k] = x[k] ^ (~x[(k+1)%5] & x[(k+2)%5]);
        return y;
    endfunction

    task automatic present(input logic [4:0] x);
        logic [63:0] v;
        v = share_row(x, NS0);
        in_data  = v[W0-1:0];
        in_rand  = RW0'($urandom);
        in_valid = 1'b1;
    endtask

    // One clock of the main instance with scoreboard bookkeeping.
    task automatic cycle(input logic [4:0] expv, output bit acc);
        #1;
        acc = in_valid && in_ready && !flush;
        if (out_valid && out_ready && !flush) begin
            n_out++;
            check("out_pending", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0)
                check("out_data", 64'(recomb(64'(out_data), NS0)), 64'(exp_q.pop_front()));
        end
        if (acc) exp_q.push_back(expv);
        @(posedge clk);
        #1;
        if (flush) exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        int idx, n0;
        bit have_snap;
        logic [W0-1:0] snap;
        logic [4:0] xv [R1];
        logic [63:0] v;

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_data = '0; in_rand = '0;
        s_in_valid = 1'b0; s_flush = 1'b0; s_out_ready = 1'b1;
        s_in_data = '0; s_in_rand = '0;

        // reset state
        #3;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_small_out_data", 64'(s_out_data), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // latency: a=1 -> 01001, out_valid two cycles after acceptance
        present(5'b00001);
        cycle(5'b01001, acc);
        check("lat_accept", 64'(acc), 64'(1));
        in_valid = 1'b0;
        check("lat_c1_valid", 64'(out_valid), 64'(0));
        cycle(5'b0, acc);
        check("lat_c2_valid", 64'(out_valid), 64'(1));
        check("lat_data", 64'(recomb(64'(out_data), NS0)), 64'(5'b01001));
        cycle(5'b0, acc);

        // 1000 random share splits / masks per pattern, streamed
        for (int p = 0; p < 4; p++) begin
            for (int n = 0; n < 1000; n++) begin
                present(pat_in[p]);
                cycle(pat_out[p], acc);
            end
        end
        in_valid = 1'b0;
        repeat (3) cycle(5'b0, acc);
        check("draws_drained", 64'(exp_q.size()), 64'(0));

        // back-to-back stream of 32
        n0 = n_out;
        for (int t = 0; t < 34; t++) begin
            if (t < 32) present(pat_in[t%4]);
            else in_valid = 1'b0;
            #1;
            if (t < 32) check("b2b_in_ready", 64'(in_ready), 64'(1));
            if (t >= 2) check("b2b_out_valid", 64'(out_valid), 64'(1));
            cycle(pat_out[t%4], acc);
        end
        check("b2b_count", 64'(n_out - n0), 64'(32));
        check("b2b_drained", 64'(exp_q.size()), 64'(0));

        // stall: out_ready low for 5 cycles, 3 inputs offered
        out_ready = 1'b0;
        idx = 0; have_snap = 1'b0; n0 = n_out;
        for (int t = 0; t < 5; t++) begin
            present(st_in[idx]);
            cycle(st_out[idx], acc);
            if (acc) idx++;
            if (out_valid) begin
                if (!have_snap) begin
                    snap = out_data;
                    have_snap = 1'b1;
                end else begin
                    check("stall_stable", 64'(out_data), 64'(snap));
                end
            end
        end
        check("stall_accepted", 64'(idx), 64'(2));
        check("stall_in_ready", 64'(in_ready), 64'(0));
        check("stall_out_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            if (idx < 3) present(st_in[idx]);
            else in_valid = 1'b0;
            cycle((idx < 3) ? st_out[idx] : 5'b0, acc);
            if (acc) idx++;
        end
        check("stall_all_accepted", 64'(idx), 64'(3));
        check("stall_outputs", 64'(n_out - n0), 64'(3));
        check("stall_drained", 64'(exp_q.size()), 64'(0));

        // flush with two in flight plus one offered
        out_ready = 1'b0;
        present(st_in[0]); cycle(st_out[0], acc);
        present(st_in[1]); cycle(st_out[1], acc);
        check("flush_pre_valid", 64'(out_valid), 64'(1));
        present(st_in[2]);
        flush = 1'b1;
        n0 = n_out;
        cycle(st_out[2], acc);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'(0));
        check("flush_in_ready", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        repeat (4) cycle(5'b0, acc);
        check("flush_nothing", 64'(n_out - n0), 64'(0));
        check("flush_after_valid", 64'(out_valid), 64'(0));

        // asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        present(st_in[0]); cycle(st_out[0], acc);
        present(st_in[1]); cycle(st_out[1], acc);
        present(st_in[2]);
        check("rstmid_pre_valid", 64'(out_valid), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("rstmid_out_valid", 64'(out_valid), 64'(0));
        check("rstmid_out_data", 64'(out_data), 64'(0));
        check("rstmid_in_ready", 64'(in_ready), 64'(1));
        exp_q.delete();
        in_valid = 1'b0;
        #3 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n0 = n_out;
        repeat (4) cycle(5'b0, acc);
        check("rstmid_nothing", 64'(n_out - n0), 64'(0));

        // D=1, ROWS=4: each row slot sweeps all 32 inputs, distinct per row
        for (int t = 0; t < 32; t++) begin
            for (int r = 0; r < R1; r++) begin
                xv[r] = 5'((t + 8*r) % 32);
                v = share_row(xv[r], NS1);
                s_in_data[r*10 +: 10] = v[9:0];
            end
            s_in_rand  = RW1'($urandom);
            s_in_valid = 1'b1;
            #1;
            check("small_in_ready", 64'(s_in_ready), 64'(1));
            @(posedge clk);
            #1 s_in_valid = 1'b0;
            @(posedge clk);
            #1;
            check("small_out_valid", 64'(s_out_valid), 64'(1));
            for (int r = 0; r < R1; r++) begin
                v = 64'(s_out_data[r*10 +: 10]);
                check($sformatf("small_row%0d_in%0d", r, xv[r]),
                      64'(recomb(v, NS1)), 64'(chi5(xv[r])));
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
